load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store unit over a word-wide memory with sub-word read-modify-write
// Optional misalignment trap: define LSU_MISALIGN_TRAP_EN; otherwise misaligned addresses are forced aligned.
module load_store_unit (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ReqValid,
    input  logic        ReqWrite,
    input  logic [1:0]  ReqSize,
    input  logic        ReqSigned,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
    output logic        Stall,
    output logic        RespValid,
    output logic [31:0] RespRData,
    output logic        Misaligned,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] MemAddress,
    output logic [31:0] MemWriteData,
    input  logic [31:0] MemReadData
);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP, ERR} state_t;

    state_t      state_q, state_d;
    logic        write_q, signed_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, cap_q, rdata_q;
    logic [31:0] req_addr, load_value, merged_word;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

`ifdef LSU_MISALIGN_TRAP_EN
    logic req_misaligned;
    assign req_misaligned = (ReqSize == 2'b01 && ReqAddr[0]) ||
                            (ReqSize[1] && ReqAddr[1:0] != 2'b00);
    assign req_addr = ReqAddr;
`else
    always_comb begin
        req_addr = ReqAddr;
        if (ReqSize[1])
            req_addr[1:0] = 2'b00;
        else if (ReqSize == 2'b01)
            req_addr[0] = 1'b0;
    end
`endif

    // Lane extraction for loads and lane replacement for sub-word stores, both off the captured word
    always_comb begin
        case (addr_q[1:0])
            2'd0:    lane_byte = cap_q[7:0];
            2'd1:    lane_byte = cap_q[15:8];
            2'd2:    lane_byte = cap_q[23:16];
            default: lane_byte = cap_q[31:24];
        endcase
        lane_half = addr_q[1] ? cap_q[31:16] : cap_q[15:0];

        if (size_q[1])
            load_value = cap_q;
        else if (size_q[0])
            load_value = {{16{signed_q & lane_half[15]}}, lane_half};
        else
            load_value = {{24{signed_q & lane_byte[7]}}, lane_byte};

        merged_word = cap_q;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'd0:    merged_word[7:0]   = wdata_q[7:0];
                2'd1:    merged_word[15:8]  = wdata_q[7:0];
                2'd2:    merged_word[23:16] = wdata_q[7:0];
                default: merged_word[31:24] = wdata_q[7:0];
            endcase
        end else if (size_q == 2'b01) begin
            if (addr_q[1])
                merged_word[31:16] = wdata_q[15:0];
            else
                merged_word[15:0] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ReqValid) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    if (req_misaligned)
                        state_d = ERR;
                    else
`endif
                    if (ReqWrite && ReqSize[1])
                        state_d = WR;
                    else
                        state_d = RD;
                end
            end
            RD:      state_d = CAP;
            CAP:     state_d = write_q ? WR : RESP;
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            cap_q    <= 32'd0;
            rdata_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && ReqValid) begin
                write_q  <= ReqWrite;
                signed_q <= ReqSigned;
                size_q   <= ReqSize;
                addr_q   <= req_addr;
                wdata_q  <= ReqWData;
            end
            if (state_q == RD)
                cap_q <= MemReadData;
            // cap_q is reused to hold the merged word so WR needs no extra register
            if (state_q == CAP) begin
                if (write_q)
                    cap_q <= merged_word;
                else
                    rdata_q <= load_value;
            end
        end
    end

    assign Stall        = (state_q != IDLE);
    assign RespValid    = (state_q == RESP) || (state_q == ERR);
`ifdef LSU_MISALIGN_TRAP_EN
    assign Misaligned   = (state_q == ERR);
`else
    assign Misaligned   = 1'b0;
`endif
    assign RespRData    = (state_q == ERR) ? 32'd0 : rdata_q;
    assign MemRead      = (state_q == RD) && !Reset;
    assign MemWrite     = (state_q == WR) && !Reset;
    assign MemAddress   = {2'b00, addr_q[31:2]};
    assign MemWriteData = (state_q == WR) ? (size_q[1] ? wdata_q : cap_q) : 32'd0;

endmodule
